// File: rtl/fsk_phase_sequencer.sv
// Continuous-phase 2-FSK phase sequencer for the sine lookup.
// Buffers one payload bit ahead and steps the phase once per sample strobe.
module fsk_phase_sequencer #(
    parameter int PHASE_RES = 3,
    parameter int SPS       = 8,
    parameter int F0_STEP   = 1,
    parameter int F1_STEP   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic                 bit_valid,
    input  logic                 bit_data,
    output logic                 bit_ready,
    output logic [PHASE_RES-1:0] phase,
    output logic                 phase_valid,
    output logic                 symbol_done,
    output logic                 busy
);

    localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(SPS - 1);
    localparam logic [PHASE_RES-1:0] STEP0 = PHASE_RES'(F0_STEP);
    localparam logic [PHASE_RES-1:0] STEP1 = PHASE_RES'(F1_STEP);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                 state_q;
    logic [PHASE_RES-1:0]   phase_q;
    logic [PHASE_RES-1:0]   phase_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   cur_q;
    logic                   nxt_q;
    logic                   nxt_full_q;
    logic                   xfer;
    logic                   boundary;

    assign bit_ready   = (state_q == IDLE) || !nxt_full_q;
    assign xfer        = bit_valid && bit_ready;
    assign boundary    = (state_q == RUN) && sample_en && (cnt_q == LAST);
    assign phase_d     = phase_q + (cur_q ? STEP1 : STEP0);
    assign cnt_d       = cnt_q + 1'b1;

    assign phase       = phase_q;
    assign phase_valid = (state_q == RUN);
    assign symbol_done = boundary;
    assign busy        = (state_q == RUN) || nxt_full_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            cnt_q      <= '0;
            cur_q      <= 1'b0;
            nxt_q      <= 1'b0;
            nxt_full_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    phase_q <= '0;
                    cnt_q   <= '0;
                    if (xfer) begin
                        cur_q   <= bit_data;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (boundary) begin
                        cnt_q <= '0;
                        if (nxt_full_q) begin
                            cur_q      <= nxt_q;
                            nxt_full_q <= 1'b0;
                            phase_q    <= phase_d;
                        end else if (xfer) begin
                            // bypass: the buffer stays empty
                            cur_q   <= bit_data;
                            phase_q <= phase_d;
                        end else begin
                            phase_q <= '0;
                            state_q <= IDLE;
                        end
                    end else begin
                        if (sample_en) begin
                            phase_q <= phase_d;
                            cnt_q   <= cnt_d;
                        end
                        if (xfer) begin
                            nxt_q      <= bit_data;
                            nxt_full_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsk_phase_sequencer.sv
// Directed bench for fsk_phase_sequencer: vector table plus reset sequence.
// A second instance with F1_STEP = 3 covers the phase-wrap case.
module tb_fsk_phase_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_en = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_data = 1'b0;

    logic       rdy1, pv1, sd1, bsy1;
    logic [2:0] ph1;
    logic       rdy2, pv2, sd2, bsy2;
    logic [2:0] ph2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fsk_phase_sequencer #(
        .PHASE_RES(3), .SPS(8), .F0_STEP(1), .F1_STEP(2)
    ) dut1 (
        .clk(clk), .reset(reset), .sample_en(sample_en),
        .bit_valid(bit_valid), .bit_data(bit_data),
        .bit_ready(rdy1), .phase(ph1), .phase_valid(pv1),
        .symbol_done(sd1), .busy(bsy1)
    );

    fsk_phase_sequencer #(
        .PHASE_RES(3), .SPS(8), .F0_STEP(1), .F1_STEP(3)
    ) dut2 (
        .clk(clk), .reset(reset), .sample_en(sample_en),
        .bit_valid(bit_valid), .bit_data(bit_data),
        .bit_ready(rdy2), .phase(ph2), .phase_valid(pv2),
        .symbol_done(sd2), .busy(bsy2)
    );

    typedef struct {
        logic       en;
        logic       v;
        logic       d;
        logic       dut;
        logic [2:0] ph;
        logic       pv;
        logic       sd;
        logic       rdy;
        logic       bsy;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic en, input logic v,
                                input logic d, input logic dut,
                                input int ph, input logic pv,
                                input logic sd, input logic rdy,
                                input logic bsy);
        vec_t t;
        t.en = en; t.v = v; t.d = d; t.dut = dut;
        t.ph = 3'(ph); t.pv = pv; t.sd = sd;
        t.rdy = rdy; t.bsy = bsy;
        vq.push_back(t);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int ph;
        // 1: single bit 0, strobe every cycle
        add(1, 1, 0, 0, 0, 0, 0, 1, 0);
        for (int c = 1; c <= 8; c++)
            add(1, 0, 0, 0, c - 1, 1, c == 8, 1, 1);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0);
        // 2: bits 1,0 back-to-back, second one buffered
        add(1, 1, 1, 0, 0, 0, 0, 1, 0);
        add(1, 1, 0, 0, 0, 1, 0, 1, 1);
        for (int c = 2; c <= 8; c++)
            add(1, 0, 0, 0, (2 * (c - 1)) % 8, 1, c == 8, 0, 1);
        for (int c = 9; c <= 16; c++)
            add(1, 0, 0, 0, c - 9, 1, c == 16, 1, 1);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0);
        // 3: bypass on the boundary cycle with empty buffer
        add(1, 1, 0, 0, 0, 0, 0, 1, 0);
        for (int c = 1; c <= 7; c++)
            add(1, 0, 0, 0, c - 1, 1, 0, 1, 1);
        add(1, 1, 1, 0, 7, 1, 1, 1, 1);
        for (int c = 9; c <= 16; c++)
            add(1, 0, 0, 0, (2 * (c - 9)) % 8, 1, c == 16, 1, 1);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0);
        // 4: strobe every 3rd cycle, bit 1 buffered during a gap
        add(1, 1, 0, 0, 0, 0, 0, 1, 0);
        for (int c = 1; c <= 24; c++)
            add(c % 3 == 0, c == 10, c == 10, 0, (c - 1) / 3, 1,
                c == 24, c <= 10, 1);
        for (int c = 25; c <= 48; c++) begin
            ph = (2 * ((c - 1) / 3 - 8)) % 8;
            add(c % 3 == 0, 0, 0, 0, ph, 1, c == 48, 1, 1);
        end
        add(0, 0, 0, 0, 0, 0, 0, 1, 0);
        // 5: F1_STEP = 3 instance, bits 1,1
        add(1, 1, 1, 1, 0, 0, 0, 1, 0);
        add(1, 1, 1, 1, 0, 1, 0, 1, 1);
        for (int c = 2; c <= 8; c++)
            add(1, 0, 0, 1, (3 * (c - 1)) % 8, 1, c == 8, 0, 1);
        for (int c = 9; c <= 16; c++)
            add(1, 0, 0, 1, (3 * (c - 9)) % 8, 1, c == 16, 1, 1);
        add(1, 0, 0, 1, 0, 0, 0, 1, 0);

        repeat (2) @(negedge clk);
        check("rst phase", ph1, 0);
        check("rst phase_valid", pv1, 0);
        check("rst symbol_done", sd1, 0);
        check("rst busy", bsy1, 0);
        check("rst phase dut2", ph2, 0);
        reset = 1'b0;
        #1;
        check("post-rst bit_ready", rdy1, 1);

        foreach (vq[i]) begin
            @(posedge clk);
            #1;
            sample_en = vq[i].en;
            bit_valid = vq[i].v;
            bit_data  = vq[i].d;
            @(negedge clk);
            if (vq[i].dut) begin
                check($sformatf("vec%0d phase2", i), ph2, vq[i].ph);
                check($sformatf("vec%0d pv2", i), pv2, vq[i].pv);
                check($sformatf("vec%0d sd2", i), sd2, vq[i].sd);
                check($sformatf("vec%0d rdy2", i), rdy2, vq[i].rdy);
                check($sformatf("vec%0d busy2", i), bsy2, vq[i].bsy);
            end else begin
                check($sformatf("vec%0d phase", i), ph1, vq[i].ph);
                check($sformatf("vec%0d pv", i), pv1, vq[i].pv);
                check($sformatf("vec%0d sd", i), sd1, vq[i].sd);
                check($sformatf("vec%0d rdy", i), rdy1, vq[i].rdy);
                check($sformatf("vec%0d busy", i), bsy1, vq[i].bsy);
            end
        end

        // 6: async reset at cnt = 4 with a bit buffered
        @(posedge clk); #1;
        sample_en = 1'b1; bit_valid = 1'b1; bit_data = 1'b0;
        @(posedge clk); #1;
        bit_data = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre-rst phase", ph1, 4);
        check("pre-rst busy", bsy1, 1);
        check("pre-rst ready", rdy1, 0);
        #1 reset = 1'b1;
        #1;
        check("mid-rst phase", ph1, 0);
        check("mid-rst phase_valid", pv1, 0);
        check("mid-rst symbol_done", sd1, 0);
        check("mid-rst busy", bsy1, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel-rst ready", rdy1, 1);
        @(posedge clk); #1;
        bit_valid = 1'b1; bit_data = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b0;
        @(negedge clk);
        check("restart phase", ph1, 0);
        check("restart pv", pv1, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("restart step", ph1, 2);
        check("restart busy", bsy1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
